// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Goldschmidt fpdiv control sequencer driving registered selects, enables, rm, busy and done.
// Define FPDIV_CTRL_STALL_EN to add a stall input that freezes the sequence.
module fpdiv_ctrl #(
    parameter int ITERS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef FPDIV_CTRL_STALL_EN
    input  logic       stall,
`endif
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       rm,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(ITERS + 1);

    typedef enum logic [2:0] {IDLE, INIT_A, INIT_B, ITER_A, ITER_B, REM, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;

    // Outputs are loaded with the values of the state being entered, so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            en_a     <= 1'b0;
            en_b     <= 1'b0;
            en_rem   <= 1'b0;
            sel_mux3 <= 2'b00;
            sel_mux4 <= 2'b00;
            rm       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end
`ifdef FPDIV_CTRL_STALL_EN
        else if (stall && state_q != IDLE && state_q != DONE) begin
            en_a   <= 1'b0;
            en_b   <= 1'b0;
            en_rem <= 1'b0;
        end
`endif
        else begin
            en_a   <= 1'b0;
            en_b   <= 1'b0;
            en_rem <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= CW'(1);
                    if (start) begin
                        state_q  <= INIT_A;
                        sel_mux4 <= 2'b00;
                        sel_mux3 <= 2'b00;
                        en_a     <= 1'b1;
                        rm       <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                INIT_A: begin
                    state_q  <= INIT_B;
                    sel_mux4 <= 2'b01;
                    en_b     <= 1'b1;
                end
                INIT_B: begin
                    if (ITERS > 1) begin
                        state_q  <= ITER_A;
                        sel_mux4 <= 2'b10;
                        sel_mux3 <= 2'b01;
                        en_a     <= 1'b1;
                    end else begin
                        state_q  <= REM;
                        sel_mux4 <= 2'b10;
                        sel_mux3 <= 2'b10;
                        en_rem   <= 1'b1;
                    end
                end
                ITER_A: begin
                    state_q  <= ITER_B;
                    sel_mux4 <= 2'b11;
                    en_b     <= 1'b1;
                end
                ITER_B: begin
                    cnt_q    <= cnt_q + CW'(1);
                    sel_mux4 <= 2'b10;
                    if (cnt_q + CW'(1) == CW'(ITERS)) begin
                        state_q  <= REM;
                        sel_mux3 <= 2'b10;
                        en_rem   <= 1'b1;
                    end else begin
                        state_q  <= ITER_A;
                        en_a     <= 1'b1;
                    end
                end
                REM: begin
                    state_q <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    state_q  <= IDLE;
                    sel_mux4 <= 2'b00;
                    sel_mux3 <= 2'b00;
                    rm       <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: randomized self-checking bench for fpdiv_ctrl against a cycle-indexed reference model.
module tb_fpdiv_ctrl;
    logic clk = 1'b0;
    logic rst6 = 1'b1, rst1 = 1'b1, start6 = 1'b0, start1 = 1'b0;
`ifdef FPDIV_CTRL_STALL_EN
    logic stall = 1'b0;
`endif
    logic a6, b6, r6, rm6, bz6, d6, a1, b1, r1, rm1, bz1, d1;
    logic [1:0] s3_6, s4_6, s3_1, s4_1;
    logic [9:0] o6, o1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign o6 = {a6, b6, r6, s3_6, s4_6, rm6, bz6, d6};
    assign o1 = {a1, b1, r1, s3_1, s4_1, rm1, bz1, d1};

    fpdiv_ctrl #(.ITERS(6)) u6 (
        .clk(clk), .reset(rst6), .start(start6),
`ifdef FPDIV_CTRL_STALL_EN
        .stall(stall),
`endif
        .en_a(a6), .en_b(b6), .en_rem(r6), .sel_mux3(s3_6), .sel_mux4(s4_6),
        .rm(rm6), .busy(bz6), .done(d6)
    );

    fpdiv_ctrl #(.ITERS(1)) u1 (
        .clk(clk), .reset(rst1), .start(start1),
`ifdef FPDIV_CTRL_STALL_EN
        .stall(stall),
`endif
        .en_a(a1), .en_b(b1), .en_rem(r1), .sel_mux3(s3_1), .sel_mux4(s4_1),
        .rm(rm1), .busy(bz1), .done(d1)
    );

    // Expected {en_a,en_b,en_rem,sel_mux3,sel_mux4,rm,busy,done} in cycle n after start was sampled.
    function automatic logic [9:0] exp_out(int iters, int n);
        if (n < 1 || n > 2 * iters + 2) return 10'd0;
        if (n == 2 * iters + 2) return {3'b000, 2'b10, 2'b10, 3'b111};
        if (n == 2 * iters + 1) return {3'b001, 2'b10, 2'b10, 3'b110};
        if (n == 1) return {3'b100, 2'b00, 2'b00, 3'b110};
        if (n == 2) return {3'b010, 2'b00, 2'b01, 3'b110};
        if (n % 2 == 1) return {3'b100, 2'b01, 2'b10, 3'b110};
        return {3'b010, 2'b01, 2'b11, 3'b110};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int k;
        rst6 = 1'b1;
        rst1 = 1'b1;
        tick();
        tick();
        total++;
        if (o6 !== 10'd0) begin bad++; $display("FAIL reset6 got=%b exp=%b", o6, 10'd0); end
        total++;
        if (o1 !== 10'd0) begin bad++; $display("FAIL reset1 got=%b exp=%b", o1, 10'd0); end
        rst6 = 1'b0;
        rst1 = 1'b0;
        tick();
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        k = $urandom_range(1, 10);
        repeat (k) tick();
        #2 rst6 = 1'b1;
        #1;
        total++;
        if (o6 !== 10'd0) begin bad++; $display("FAIL async_reset k=%0d got=%b exp=%b", k, o6, 10'd0); end
        tick();
        rst6 = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            start6 = 1'b1;
            tick();
            start6 = 1'b0;
            for (int n = 1; n <= 16; n++) begin
                total++;
                if (o6 !== exp_out(6, n)) begin
                    bad++;
                    $display("FAIL nominal r=%0d n=%0d got=%b exp=%b", r, n, o6, exp_out(6, n));
                end
                tick();
            end
        end
    endtask

    task automatic test_iters1();
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            for (int n = 1; n <= 6; n++) begin
                total++;
                if (o1 !== exp_out(1, n)) begin
                    bad++;
                    $display("FAIL iters1 n=%0d got=%b exp=%b", n, o1, exp_out(1, n));
                end
                total++;
                if (s3_1 === 2'b01) begin
                    bad++;
                    $display("FAIL iters1_sel3 n=%0d got=%b exp=not 01", n, s3_1);
                end
                tick();
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            total++;
            if (o6 !== exp_out(6, n)) begin
                bad++;
                $display("FAIL ignore_start n=%0d got=%b exp=%b", n, o6, exp_out(6, n));
            end
            dones += int'(d6);
            start6 = (n >= 2 && n <= 14) ? (n == 5 || $urandom_range(0, 1) == 1) : 1'b0;
            tick();
        end
        start6 = 1'b0;
        total++;
        if (dones != 1) begin bad++; $display("FAIL ignore_start_dones got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        int m;
        logic [9:0] e;
        start6 = 1'b1;
        tick();
        for (int n = 1; n <= 40; n++) begin
            m = (n - 1) % 15 + 1;
            e = (m == 15) ? 10'd0 : exp_out(6, m);
            total++;
            if (o6 !== e) begin
                bad++;
                $display("FAIL back_to_back n=%0d got=%b exp=%b", n, o6, e);
            end
            tick();
        end
        start6 = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        int k;
        for (int r = 0; r < 3; r++) begin
            k = (r == 0) ? 8 : $urandom_range(3, 13);
            start6 = 1'b1;
            tick();
            start6 = 1'b0;
            for (int n = 1; n < k; n++) tick();
            total++;
            if (o6 !== exp_out(6, k)) begin
                bad++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, o6, exp_out(6, k));
            end
            #2 rst6 = 1'b1;
            #1;
            total++;
            if (o6 !== 10'd0) begin bad++; $display("FAIL mid_reset k=%0d got=%b exp=%b", k, o6, 10'd0); end
            tick();
            rst6 = 1'b0;
            tick();
            total++;
            if (o6 !== 10'd0) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", o6, 10'd0); end
            start6 = 1'b1;
            tick();
            start6 = 1'b0;
            for (int n = 1; n <= 15; n++) begin
                total++;
                if (o6 !== exp_out(6, n)) begin
                    bad++;
                    $display("FAIL restart n=%0d got=%b exp=%b", n, o6, exp_out(6, n));
                end
                tick();
            end
        end
    endtask

`ifdef FPDIV_CTRL_STALL_EN
    task automatic test_stall();
        int s;
        logic [9:0] e;
        s = 3 + 2 * $urandom_range(0, 4);
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            e = (n <= s) ? exp_out(6, n) : (n <= s + 3) ? (exp_out(6, s) & 10'b0001111111) : exp_out(6, n - 3);
            total++;
            if (o6 !== e) begin
                bad++;
                $display("FAIL stall s=%0d n=%0d got=%b exp=%b", s, n, o6, e);
            end
            stall = (n >= s && n <= s + 2);
            tick();
        end
        stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_iters1();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef FPDIV_CTRL_STALL_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
